// File: rtl/edge_detect_mc_if.sv
// Level-input / event-output bundle for edge_detect_mc.
// master drives the levels, modes and clear strobes; slave is the detector.
interface edge_detect_mc_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]       data_in;
    logic [2*WIDTH-1:0]     mode;
    logic [WIDTH-1:0]       status_clr;
    logic [WIDTH-1:0]       cnt_clr;
    logic [WIDTH-1:0]       pulse_out;
    logic [WIDTH-1:0]       status;
    logic [WIDTH*CNT_W-1:0] count;
    logic                   irq;

    modport master (
        output data_in, mode, status_clr, cnt_clr,
        input  pulse_out, status, count, irq
    );

    modport slave (
        input  data_in, mode, status_clr, cnt_clr,
        output pulse_out, status, count, irq
    );
endinterface

// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector: synchroniser, per-channel edge mode, sticky status, saturating counters.
// Optional 3-sample deglitch filter ahead of the detector when EDGE_DEGLITCH_EN is defined.
module edge_detect_mc #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    edge_detect_mc_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic edge_event(input logic [1:0] md, input logic rise, input logic fall);
        logic ev;
        case (md)
            2'b01:   ev = rise;
            2'b10:   ev = fall;
            2'b11:   ev = rise | fall;
            default: ev = 1'b0;
        endcase
        return ev;
    endfunction

    logic [WIDTH-1:0] sync_lvl_s;
    logic [WIDTH-1:0] lvl_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sync_lvl_s = bus.data_in;
        end else begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];
            logic [WIDTH-1:0] sync_d [SYNC_STAGES];

            // Next value of each synchroniser stage: shift the raw input down the chain.
            always_comb begin
                sync_d[0] = bus.data_in;
                for (int j = 1; j < SYNC_STAGES; j++) begin
                    sync_d[j] = sync_q[j-1];
                end
            end

            // Synchroniser flops.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int j = 0; j < SYNC_STAGES; j++) begin
                        sync_q[j] <= {WIDTH{1'b0}};
                    end
                end else begin
                    sync_q <= sync_d;
                end
            end

            assign sync_lvl_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] pulse_q, pulse_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

`ifdef EDGE_DEGLITCH_EN
    // The filter's held level is p itself: the detector compares the new filtered level against it.
    logic [WIDTH-1:0] h1_q, h1_d;
    logic [WIDTH-1:0] h2_q, h2_d;
    logic [WIDTH-1:0] stable_s;

    // Filtered level moves only when the last three samples of s agree.
    always_comb begin
        h1_d     = sync_lvl_s;
        h2_d     = h1_q;
        stable_s = ~(sync_lvl_s ^ h1_q) & ~(sync_lvl_s ^ h2_q);
        lvl_s    = (stable_s & sync_lvl_s) | (~stable_s & p_q);
    end

    // Deglitch sample history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h1_q <= {WIDTH{1'b0}};
            h2_q <= {WIDTH{1'b0}};
        end else begin
            h1_q <= h1_d;
            h2_q <= h2_d;
        end
    end
`else
    assign lvl_s = sync_lvl_s;
`endif

    // Per-channel event qualification, sticky status and saturating count.
    always_comb begin
        p_d      = lvl_s;
        pulse_d  = {WIDTH{1'b0}};
        status_d = status_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            pulse_d[i]  = edge_event(bus.mode[2*i +: 2], lvl_s[i] & ~p_q[i], ~lvl_s[i] & p_q[i]);
            // Set beats clear when both land in the same cycle.
            status_d[i] = pulse_d[i] | (status_q[i] & ~bus.status_clr[i]);
            if (bus.cnt_clr[i]) begin
                cnt_d[i] = pulse_d[i] ? CNT_ONE : {CNT_W{1'b0}};
            end else if (pulse_d[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Detector history, pulse, status and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q      <= {WIDTH{1'b0}};
            pulse_q  <= {WIDTH{1'b0}};
            status_q <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            p_q      <= p_d;
            pulse_q  <= pulse_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.pulse_out = pulse_q;
    assign bus.status    = status_q;
    assign bus.count     = cnt_q;
    assign bus.irq       = |status_q;

endmodule
